// File: rtl/writeback_unit_pkg.sv
// Purpose : shared constants, state type and write-strobe helper for the writeback unit.
// Latency : n/a (declarations only).
// Backpres: n/a.
// Contents: RW_* write-strobe encodings, wb_state_t FSM states, wb_eff_rw() strobe filter.
package wb_pkg;

  // Register-file write strobe encodings (rwin).
  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_GPR  = 2'b01;
  localparam logic [1:0] RW_FPR  = 2'b10;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_WAIT  = 2'd1,
    IN_COLLECT = 2'd2
  } wb_state_t;

  // Strobe that will actually reach the register file for a retiring
  // instruction: r0 is hard-wired zero so GPR writes to it are dropped,
  // f0 is an ordinary register, and the unused 2'b11 code means "no write".
  function automatic logic [1:0] wb_eff_rw(input logic [1:0] rw, input logic [4:0] rd);
    logic [1:0] eff;
    eff = RW_NONE;
    if (rw == RW_FPR) begin
      eff = RW_FPR;
    end else if ((rw == RW_GPR) && (rd != 5'd0)) begin
      eff = RW_GPR;
    end
    return eff;
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Purpose : bundles the execute handshake, memory/UART inputs and register-file write port.
// Latency : n/a (wiring only).
// Backpres: ex_ready / uart_ready are driven by the unit (slave side).
// Modports: master = execute/memory/UART environment, slave = writeback_unit.
interface writeback_unit_if;

  // Execute -> writeback retire handshake.
  logic        ex_valid;
  logic        ex_ready;
  logic [1:0]  ex_rw;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic        ex_is_in;

  // BRAM read data for loads.
  logic [31:0] mem_rdata;

  // UART receive byte stream.
  logic        uart_valid;
  logic [7:0]  uart_data;
  logic        uart_ready;

  // Register-file write port and status.
  logic [1:0]  rwin;
  logic [31:0] dtowrite;
  logic [4:0]  rdin;
  logic        busy;

  modport master (
    output ex_valid, ex_rw, ex_rd, ex_result, ex_is_load, ex_is_in,
    output mem_rdata, uart_valid, uart_data,
    input  ex_ready, uart_ready, rwin, dtowrite, rdin, busy
  );

  modport slave (
    input  ex_valid, ex_rw, ex_rd, ex_result, ex_is_load, ex_is_in,
    input  mem_rdata, uart_valid, uart_data,
    output ex_ready, uart_ready, rwin, dtowrite, rdin, busy
  );

endinterface

// File: rtl/writeback_unit_in_assembler.sv
// Purpose : packs IN_BYTES UART bytes little-endian into a 32-bit word, flags the last byte.
// Latency : combinational o_word/o_done in the cycle the last byte is presented.
// Backpres: none of its own; the caller decides when a byte counts as consumed.
// Ports   : clk, rstn; i_start clears word/index; i_byte_vld/i_byte supply a byte;
//           o_word = word including the byte on i_byte; o_done = this byte completes the word.
module in_assembler #(
  parameter int IN_BYTES = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_start,
  input  logic        i_byte_vld,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_done
);

  localparam logic [1:0] LAST_IDX = 2'(IN_BYTES - 1);

  logic [1:0]  r_idx;
  logic [31:0] r_word;
  logic [4:0]  w_shamt;

  // Byte k lands in bits [8k+7:8k]; untouched upper bytes stay zero because
  // the word is cleared on every start.
  assign w_shamt = {r_idx, 3'b000};
  assign o_word  = r_word | ({24'd0, i_byte} << w_shamt);
  assign o_done  = i_byte_vld & (r_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idx  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_start) begin
      r_idx  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_byte_vld) begin
      r_word <= o_word;
      r_idx  <= o_done ? 2'd0 : r_idx + 2'd1;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Purpose : final pipeline stage; retires one instruction, writes ALU/FPU, load or UART-IN data to the register file.
// Latency : plain result 1 cycle; load LOAD_LATENCY+1 cycles; IN one cycle after the last byte is consumed.
// Backpres: ex_ready only in IDLE; uart_ready = uart_valid only while collecting an IN word.
// Ports   : clk, rstn (async active-low); bus = writeback_unit_if.slave (ex_*, mem_rdata, uart_*, rwin/dtowrite/rdin, busy).
// Config  : WB_STATS_EN adds output wb_count[31:0], counting cycles with rwin != 00 (wraps).
module writeback_unit
  import wb_pkg::*;
#(
  parameter int LOAD_LATENCY = 2,
  parameter int IN_BYTES     = 4
) (
  input  logic             clk,
  input  logic             rstn,
  writeback_unit_if.slave  bus
`ifdef WB_STATS_EN
  ,
  output logic [31:0]      wb_count
`endif
);

  localparam logic [1:0] ST_IDLE       = IDLE;
  localparam logic [1:0] ST_LOAD_WAIT  = LOAD_WAIT;
  localparam logic [1:0] ST_IN_COLLECT = IN_COLLECT;

  // Counter only has to hold LOAD_LATENCY-1.
  localparam int              LD_CW   = (LOAD_LATENCY > 2) ? $clog2(LOAD_LATENCY) : 1;
  localparam logic [LD_CW-1:0] LD_INIT = LD_CW'(LOAD_LATENCY - 1);

  logic [1:0]       r_state;
  logic [LD_CW-1:0] r_ld_cnt;
  logic [1:0]       r_pend_rw;
  logic [4:0]       r_pend_rd;
  logic [1:0]       r_rwin;
  logic [4:0]       r_rdin;
  logic [31:0]      r_dtowrite;

  logic        w_idle;
  logic        w_collect;
  logic        w_accept;
  logic [1:0]  w_eff_rw;
  logic        w_in_start;
  logic        w_in_byte_vld;
  logic [31:0] w_in_word;
  logic        w_in_done;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_collect = (r_state == ST_IN_COLLECT);
  assign w_accept  = bus.ex_valid & w_idle;
  assign w_eff_rw  = wb_eff_rw(bus.ex_rw, bus.ex_rd);

  // A load flag overrides an IN flag if execute ever raises both.
  assign w_in_start    = w_accept & ~bus.ex_is_load & bus.ex_is_in;
  assign w_in_byte_vld = w_collect & bus.uart_valid;

  assign bus.ex_ready   = w_idle;
  assign bus.uart_ready = w_in_byte_vld;
  assign bus.busy       = ~w_idle;
  assign bus.rwin       = r_rwin;
  assign bus.rdin       = r_rdin;
  assign bus.dtowrite   = r_dtowrite;

  in_assembler #(
    .IN_BYTES (IN_BYTES)
  ) u_in_asm (
    .clk        (clk),
    .rstn       (rstn),
    .i_start    (w_in_start),
    .i_byte_vld (w_in_byte_vld),
    .i_byte     (bus.uart_data),
    .o_word     (w_in_word),
    .o_done     (w_in_done)
  );

  // Pending destination is latched with the already-filtered strobe, so a
  // load or IN aimed at r0 still waits for its data but never writes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_ld_cnt   <= '0;
      r_pend_rw  <= RW_NONE;
      r_pend_rd  <= 5'd0;
      r_rwin     <= RW_NONE;
      r_rdin     <= 5'd0;
      r_dtowrite <= 32'd0;
    end else begin
      // Write strobe is a single-cycle pulse; only a commit below raises it.
      r_rwin <= RW_NONE;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (bus.ex_is_load) begin
              r_pend_rw <= w_eff_rw;
              r_pend_rd <= bus.ex_rd;
              r_ld_cnt  <= LD_INIT;
              r_state   <= ST_LOAD_WAIT;
            end else if (bus.ex_is_in) begin
              r_pend_rw <= w_eff_rw;
              r_pend_rd <= bus.ex_rd;
              r_state   <= ST_IN_COLLECT;
            end else begin
              r_rwin     <= w_eff_rw;
              r_rdin     <= bus.ex_rd;
              r_dtowrite <= bus.ex_result;
            end
          end
        end
        ST_LOAD_WAIT: begin
          // Count reaches zero on the edge where BRAM data is valid.
          if (r_ld_cnt == '0) begin
            r_rwin     <= r_pend_rw;
            r_rdin     <= r_pend_rd;
            r_dtowrite <= bus.mem_rdata;
            r_state    <= ST_IDLE;
          end else begin
            r_ld_cnt <= r_ld_cnt - 1'b1;
          end
        end
        ST_IN_COLLECT: begin
          if (w_in_done) begin
            r_rwin     <= r_pend_rw;
            r_rdin     <= r_pend_rd;
            r_dtowrite <= w_in_word;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef WB_STATS_EN
  logic [31:0] r_wb_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wb_count <= 32'd0;
    end else if (r_rwin != RW_NONE) begin
      r_wb_count <= r_wb_count + 32'd1;
    end
  end

  assign wb_count = r_wb_count;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Purpose : self-checking bench for writeback_unit: directed scenarios plus randomized traffic.
// Latency : n/a.
// Backpres: n/a.
module tb_writeback_unit;

  localparam int LAT = 2;
  localparam int NB  = 4;

  logic clk;
  logic rstn;
  writeback_unit_if bus ();
`ifdef WB_STATS_EN
  logic [31:0] wb_count;
`endif

  writeback_unit #(
    .LOAD_LATENCY (LAT),
    .IN_BYTES     (NB)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef WB_STATS_EN
    ,
    .wb_count (wb_count)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference ----------------
  // Transaction view: a load owes a write LAT edges after acceptance, an IN
  // owes a write once NB bytes have been taken; otherwise the unit is free.
  int          ld_left   = 0;
  bit          in_active = 0;
  logic [7:0]  in_bytes[$];
  logic [1:0]  pend_rw   = 2'b00;
  logic [4:0]  pend_rd   = 5'd0;
  logic [1:0]  exp_rw    = 2'b00;
  logic [4:0]  exp_rd    = 5'd0;
  logic [31:0] exp_dat   = 32'd0;
  logic [31:0] exp_cnt   = 32'd0;

  function automatic logic [1:0] will_write(input logic [1:0] rw, input logic [4:0] rd);
    if (rw == 2'b10) return 2'b10;
    if (rw == 2'b01 && rd != 5'd0) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rstn) begin : model_step
    logic [31:0] word;
    if (!rstn) begin
      ld_left = 0; in_active = 0; in_bytes.delete();
      exp_rw = 2'b00; exp_rd = 5'd0; exp_dat = 32'd0; exp_cnt = 32'd0;
    end else begin
      if (exp_rw != 2'b00) exp_cnt = exp_cnt + 32'd1;
      exp_rw = 2'b00;
      if (ld_left != 0) begin
        ld_left--;
        if (ld_left == 0) begin
          exp_rw = pend_rw; exp_rd = pend_rd; exp_dat = bus.mem_rdata;
        end
      end else if (in_active) begin
        if (bus.uart_valid) begin
          in_bytes.push_back(bus.uart_data);
          if (in_bytes.size() == NB) begin
            word = 32'd0;
            for (int k = 0; k < NB; k++) word = word + (32'(in_bytes[k]) << (8 * k));
            exp_rw = pend_rw; exp_rd = pend_rd; exp_dat = word;
            in_active = 0;
            in_bytes.delete();
          end
        end
      end else if (bus.ex_valid) begin
        if (bus.ex_is_load) begin
          pend_rw = will_write(bus.ex_rw, bus.ex_rd); pend_rd = bus.ex_rd; ld_left = LAT;
        end else if (bus.ex_is_in) begin
          pend_rw = will_write(bus.ex_rw, bus.ex_rd); pend_rd = bus.ex_rd;
          in_active = 1; in_bytes.delete();
        end else begin
          exp_rw = will_write(bus.ex_rw, bus.ex_rd); exp_rd = bus.ex_rd; exp_dat = bus.ex_result;
        end
      end
    end
  end

  // Every cycle: compare DUT outputs against the reference.
  always @(negedge clk) begin
    logic free;
    free = (ld_left == 0) && !in_active;
    check("rwin", 32'(bus.rwin), 32'(exp_rw));
    if (exp_rw != 2'b00) begin
      check("rdin", 32'(bus.rdin), 32'(exp_rd));
      check("dtowrite", bus.dtowrite, exp_dat);
    end
    check("ex_ready", 32'(bus.ex_ready), 32'(free));
    check("busy", 32'(bus.busy), 32'(!free));
    check("uart_ready", 32'(bus.uart_ready), 32'(in_active && bus.uart_valid));
`ifdef WB_STATS_EN
    check("wb_count", wb_count, exp_cnt);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [1:0] rw, input logic [4:0] rd,
                          input logic [31:0] res, input logic ld, input logic inn);
    bus.ex_valid = v; bus.ex_rw = rw; bus.ex_rd = rd;
    bus.ex_result = res; bus.ex_is_load = ld; bus.ex_is_in = inn;
  endtask

  initial begin
    logic [7:0] inb [4];
    logic [7:0] inb2 [4];
    logic [1:0] t_rw [4];
    logic [4:0] t_rd [4];
    logic [1:0] t_exp [4];
    inb  = '{8'h11, 8'h22, 8'h33, 8'h44};
    inb2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    t_rw  = '{2'b01, 2'b00, 2'b11, 2'b10};
    t_rd  = '{5'd0,  5'd7,  5'd7,  5'd0};
    t_exp = '{2'b00, 2'b00, 2'b00, 2'b10};

    clk = 1'b0;
    rstn = 1'b1;
    drive_ex(0, 2'b00, 5'd0, 32'd0, 0, 0);
    bus.mem_rdata = 32'd0;
    bus.uart_valid = 1'b1;
    bus.uart_data = 8'h77;
    #1 rstn = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset rwin", 32'(bus.rwin), 32'd0);
    check("reset rdin", 32'(bus.rdin), 32'd0);
    check("reset dtowrite", bus.dtowrite, 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset uart_ready", 32'(bus.uart_ready), 32'd0);
    check("reset ex_ready", 32'(bus.ex_ready), 32'd1);
    step();
    rstn = 1'b1;
    bus.uart_valid = 1'b0;
    step();

    // ALU commit, one-cycle pulse
    drive_ex(1, 2'b01, 5'd5, 32'h1234, 0, 0);
    step();
    bus.ex_valid = 1'b0;
    @(negedge clk);
    check("alu rwin", 32'(bus.rwin), 32'h1);
    check("alu rdin", 32'(bus.rdin), 32'd5);
    check("alu dtowrite", bus.dtowrite, 32'h1234);
    step();
    @(negedge clk);
    check("alu pulse end", 32'(bus.rwin), 32'h0);

    // Back-to-back accepts
    for (int i = 1; i <= 3; i++) begin
      drive_ex(1, 2'b01, 5'(i), 32'hA0 + 32'(i), 0, 0);
      @(negedge clk);
      check("b2b ex_ready", 32'(bus.ex_ready), 32'd1);
      if (i > 1) check("b2b rdin", 32'(bus.rdin), 32'(i - 1));
      step();
    end
    bus.ex_valid = 1'b0;
    @(negedge clk);
    check("b2b last rdin", 32'(bus.rdin), 32'd3);
    check("b2b last dtowrite", bus.dtowrite, 32'hA3);

    // Load, latency 2
    drive_ex(1, 2'b10, 5'd8, 32'h5555_5555, 1, 0);
    step();
    bus.ex_valid = 1'b0;
    bus.mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    check("load ex_ready c1", 32'(bus.ex_ready), 32'd0);
    step();
    bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("load ex_ready c2", 32'(bus.ex_ready), 32'd0);
    check("load no early write", 32'(bus.rwin), 32'd0);
    step();
    bus.mem_rdata = 32'd0;
    @(negedge clk);
    check("load rwin", 32'(bus.rwin), 32'h2);
    check("load rdin", 32'(bus.rdin), 32'd8);
    check("load dtowrite", bus.dtowrite, 32'hDEAD_BEEF);
    check("load ex_ready back", 32'(bus.ex_ready), 32'd1);

    // IN with gaps, stray byte beforehand not consumed
    step();
    bus.uart_valid = 1'b1;
    bus.uart_data = 8'h99;
    @(negedge clk);
    check("stray uart_ready", 32'(bus.uart_ready), 32'd0);
    step();
    drive_ex(1, 2'b01, 5'd9, 32'hFFFF_FFFF, 0, 1);
    step();
    bus.ex_valid = 1'b0;
    bus.uart_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      bus.uart_valid = 1'b1;
      bus.uart_data = inb[k];
      @(negedge clk);
      check("in uart_ready", 32'(bus.uart_ready), 32'd1);
      step();
      bus.uart_valid = 1'b0;
    end
    @(negedge clk);
    check("in rwin", 32'(bus.rwin), 32'h1);
    check("in rdin", 32'(bus.rdin), 32'd9);
    check("in dtowrite", bus.dtowrite, 32'h4433_2211);

    // r0 / none / 11 / f0
    for (int j = 0; j < 4; j++) begin
      step();
      drive_ex(1, t_rw[j], t_rd[j], 32'hC0DE_0000 + 32'(j), 0, 0);
      step();
      bus.ex_valid = 1'b0;
      @(negedge clk);
      check("r0/none rwin", 32'(bus.rwin), 32'(t_exp[j]));
    end

    // Reset during IN collection
    step();
    drive_ex(1, 2'b01, 5'd10, 32'd0, 0, 1);
    step();
    bus.ex_valid = 1'b0;
    bus.uart_valid = 1'b1;
    bus.uart_data = 8'h55;
    step();
    bus.uart_data = 8'h66;
    step();
    bus.uart_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    check("midrst rwin", 32'(bus.rwin), 32'd0);
    check("midrst busy", 32'(bus.busy), 32'd0);
    step();
    rstn = 1'b1;
    @(negedge clk);
    check("postrst ex_ready", 32'(bus.ex_ready), 32'd1);
    check("postrst rwin", 32'(bus.rwin), 32'd0);
    step();
    drive_ex(1, 2'b01, 5'd11, 32'd0, 0, 1);
    step();
    bus.ex_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.uart_valid = 1'b1;
      bus.uart_data = inb2[k];
      step();
    end
    bus.uart_valid = 1'b0;
    @(negedge clk);
    check("fresh in rwin", 32'(bus.rwin), 32'h1);
    check("fresh in rdin", 32'(bus.rdin), 32'd11);
    check("fresh in dtowrite", bus.dtowrite, 32'hDDCC_BBAA);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      drive_ex($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
               $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
      bus.mem_rdata = $urandom;
      bus.uart_valid = $urandom_range(0, 4) < 2;
      bus.uart_data = 8'($urandom_range(0, 255));
    end

    step();
    drive_ex(0, 2'b00, 5'd0, 32'd0, 0, 0);
    bus.uart_valid = 1'b0;
    repeat (10) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
